// File: rtl/adc_pkg.sv
// ---------------------------------------------------------------------------
// adc_pkg
//   Shared definitions for the 8-channel, 12-bit SPI ADC front end.
//   Used by the frame scheduler, the SPI engine and downstream consumers.
//
//   Contents:
//     ADC_DATA_W / ADC_ADDR_W / ADC_NUM_CH  - sample width, channel address
//                                            width, channel count
//     sched_state_t                        - frame scheduler state encoding
//     lowest_set_bit()                     - index of lowest set mask bit
// ---------------------------------------------------------------------------
package adc_pkg;

  localparam int ADC_DATA_W = 12;
  localparam int ADC_ADDR_W = 3;
  localparam int ADC_NUM_CH = 8;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    START,
    WAIT,
    OUT
  } sched_state_t;

  // Returns the index of the lowest set bit of mask (0 when mask is empty).
  // Scanning from the top down lets the lowest hit win the last assignment.
  function automatic logic [ADC_ADDR_W-1:0] lowest_set_bit(
    input logic [ADC_NUM_CH-1:0] mask
  );
    logic [ADC_ADDR_W-1:0] idx;
    idx = '0;
    for (int i = ADC_NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = ADC_ADDR_W'(i);
      end
    end
    return idx;
  endfunction

endpackage : adc_pkg

// File: rtl/sample_tick_gen.sv
// ---------------------------------------------------------------------------
// sample_tick_gen
//   Free-running sample-period divider. The count runs 0..DIV-1 and wraps;
//   tick is high during the cycle in which the count equals DIV-1.
//
//   Ports:
//     clk      in   system clock
//     reset_n  in   synchronous active-low reset (count returns to 0)
//     tick     out  one cycle high per DIV cycles, decoded from the count
// ---------------------------------------------------------------------------
module sample_tick_gen #(
  parameter int DIV = 1042
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (count_q == LAST) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == LAST);

endmodule : sample_tick_gen

// File: rtl/adc_scheduler.sv
// ---------------------------------------------------------------------------
// adc_scheduler
//   Once per sample period, walks the enabled ADC channels in ascending
//   order: starts one SPI conversion per channel, waits for the result (or
//   gives up after TIMEOUT cycles) and hands the tagged sample downstream
//   over a valid/ready handshake.
//
//   Parameters:
//     DIV      clk cycles per sample period (>= 64)
//     TIMEOUT  max cycles waited for spi_done (1..255)
//
//   Ports:
//     clk          in   system clock
//     reset_n      in   synchronous active-low reset
//     ch_enable    in   channel mask, sampled at frame start only
//     spi_start    out  one-cycle pulse: begin conversion of spi_addr
//     spi_addr     out  channel being converted
//     spi_done     in   one-cycle pulse: spi_data valid
//     spi_data     in   conversion result
//     smp_valid    out  sample available
//     smp_ready    in   downstream accepts
//     smp_data     out  sample value
//     smp_ch       out  channel of smp_data
//     smp_last     out  last enabled channel of the frame
//     overrun      out  one-cycle pulse: tick arrived mid-frame (tick dropped)
//     timeout_err  out  one-cycle pulse: conversion abandoned
//
//   Every output is a flop or a decode of the state flop; nothing from
//   smp_ready or spi_done reaches an output combinationally.
// ---------------------------------------------------------------------------
module adc_scheduler
  import adc_pkg::*;
#(
  parameter int DIV     = 1042,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADC_NUM_CH-1:0] ch_enable,
  output logic                  spi_start,
  output logic [ADC_ADDR_W-1:0] spi_addr,
  input  logic                  spi_done,
  input  logic [ADC_DATA_W-1:0] spi_data,
  output logic                  smp_valid,
  input  logic                  smp_ready,
  output logic [ADC_DATA_W-1:0] smp_data,
  output logic [ADC_ADDR_W-1:0] smp_ch,
  output logic                  smp_last,
  output logic                  overrun,
  output logic                  timeout_err
);

  // The wait counter is 0 in the first WAIT cycle, so giving up when it
  // holds TIMEOUT-1 puts timeout_err (a flop) exactly TIMEOUT+1 cycles
  // after the spi_start cycle.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic tick;

  sample_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  sched_state_t            state_q,       state_d;
  logic [ADC_NUM_CH-1:0]   rem_mask_q,    rem_mask_d;
  logic [ADC_ADDR_W-1:0]   ch_q,          ch_d;
  logic [7:0]              wait_cnt_q,    wait_cnt_d;
  logic [ADC_DATA_W-1:0]   smp_data_q,    smp_data_d;
  logic [ADC_ADDR_W-1:0]   smp_ch_q,      smp_ch_d;
  logic                    smp_last_q,    smp_last_d;
  logic                    overrun_q,     overrun_d;
  logic                    timeout_err_q, timeout_err_d;

  always_comb begin
    state_d       = state_q;
    rem_mask_d    = rem_mask_q;
    ch_d          = ch_q;
    wait_cnt_d    = wait_cnt_q;
    smp_data_d    = smp_data_q;
    smp_ch_d      = smp_ch_q;
    smp_last_d    = smp_last_q;
    timeout_err_d = 1'b0;
    // Any tick outside IDLE is dropped and flagged; the running frame
    // carries on untouched.
    overrun_d     = tick && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (tick && (ch_enable != '0)) begin
          rem_mask_d = ch_enable;
          state_d    = SCAN;
        end
      end

      SCAN: begin
        if (rem_mask_q == '0) begin
          state_d = IDLE;
        end else begin
          ch_d       = lowest_set_bit(rem_mask_q);
          // x & (x-1) clears the lowest set bit: the channel just picked.
          rem_mask_d = rem_mask_q & (rem_mask_q - ADC_NUM_CH'(1));
          state_d    = START;
        end
      end

      START: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end

      WAIT: begin
        if (spi_done) begin
          smp_data_d = spi_data;
          smp_ch_d   = ch_q;
          smp_last_d = (rem_mask_q == '0);
          state_d    = OUT;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = SCAN;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      OUT: begin
        if (smp_ready) begin
          state_d = SCAN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rem_mask_q    <= '0;
      ch_q          <= '0;
      wait_cnt_q    <= '0;
      smp_data_q    <= '0;
      smp_ch_q      <= '0;
      smp_last_q    <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rem_mask_q    <= rem_mask_d;
      ch_q          <= ch_d;
      wait_cnt_q    <= wait_cnt_d;
      smp_data_q    <= smp_data_d;
      smp_ch_q      <= smp_ch_d;
      smp_last_q    <= smp_last_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // ch_q only changes in SCAN, so spi_addr holds from spi_start until the
  // conversion completes or is abandoned.
  assign spi_start   = (state_q == START);
  assign spi_addr    = ch_q;
  assign smp_valid   = (state_q == OUT);
  assign smp_data    = smp_data_q;
  assign smp_ch      = smp_ch_q;
  assign smp_last    = smp_last_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule : adc_scheduler

// File: tb/tb_adc_scheduler.sv
// ---------------------------------------------------------------------------
// tb_adc_scheduler
//   Directed bench for adc_scheduler. Two instances share clk/reset_n:
//   u_dut (DIV=64, TIMEOUT=255) for the frame scenarios and u_dut_to
//   (DIV=64, TIMEOUT=16) for the abandoned-conversion scenario.
//   cyc counts cycles since the last reset edge, so it equals the divider
//   count and ticks fall on cyc % 64 == 63.
// ---------------------------------------------------------------------------
module tb_adc_scheduler;
  import adc_pkg::*;

  typedef struct packed {
    int c;   // cycle
    int a;   // channel
    int d;   // data
    int l;   // last
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic [7:0]  ch_en       [2] = '{8'h00, 8'h00};
  logic        spi_start   [2];
  logic [2:0]  spi_addr    [2];
  logic        spi_done    [2] = '{1'b0, 1'b0};
  logic [11:0] spi_data    [2] = '{12'hFFF, 12'hFFF};
  logic        smp_valid   [2];
  logic        smp_ready   [2] = '{1'b1, 1'b1};
  logic [11:0] smp_data    [2];
  logic [2:0]  smp_ch      [2];
  logic        smp_last    [2];
  logic        overrun     [2];
  logic        timeout_err [2];

  adc_scheduler #(.DIV(64), .TIMEOUT(255)) u_dut (
    .clk(clk), .reset_n(reset_n), .ch_enable(ch_en[0]),
    .spi_start(spi_start[0]), .spi_addr(spi_addr[0]),
    .spi_done(spi_done[0]), .spi_data(spi_data[0]),
    .smp_valid(smp_valid[0]), .smp_ready(smp_ready[0]),
    .smp_data(smp_data[0]), .smp_ch(smp_ch[0]), .smp_last(smp_last[0]),
    .overrun(overrun[0]), .timeout_err(timeout_err[0])
  );

  adc_scheduler #(.DIV(64), .TIMEOUT(16)) u_dut_to (
    .clk(clk), .reset_n(reset_n), .ch_enable(ch_en[1]),
    .spi_start(spi_start[1]), .spi_addr(spi_addr[1]),
    .spi_done(spi_done[1]), .spi_data(spi_data[1]),
    .smp_valid(smp_valid[1]), .smp_ready(smp_ready[1]),
    .smp_data(smp_data[1]), .smp_ch(smp_ch[1]), .smp_last(smp_last[1]),
    .overrun(overrun[1]), .timeout_err(timeout_err[1])
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int gcyc  = 0;

  always @(posedge clk) begin
    gcyc <= gcyc + 1;
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // SPI engine model: done arrives lat cycles after the start cycle with
  // data {ch, 9'h0AB}; never_ch is never answered. Uses the free-running
  // gcyc so a conversion pending across a reset still completes (late).
  int         lat      [2] = '{34, 5};
  int         never_ch [2] = '{-1, 2};
  logic       pend     [2] = '{1'b0, 1'b0};
  int         done_at  [2] = '{0, 0};
  logic [2:0] m_addr   [2] = '{3'd0, 3'd0};

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      spi_done[k] = 1'b0;
      spi_data[k] = 12'hFFF;
      if (pend[k] && gcyc == done_at[k]) begin
        spi_done[k] = 1'b1;
        spi_data[k] = {m_addr[k], 9'h0AB};
        pend[k]     = 1'b0;
      end
      if (spi_start[k]) begin
        m_addr[k]  = spi_addr[k];
        pend[k]    = (int'(spi_addr[k]) != never_ch[k]);
        done_at[k] = gcyc + lat[k];
      end
    end
  end

  function automatic ev_t mk(input int c, input int a, input int d, input int l);
    ev_t e;
    e.c = c; e.a = a; e.d = d; e.l = l;
    return e;
  endfunction

  function automatic logic [22:0] outs(input int k);
    return {spi_start[k], spi_addr[k], smp_valid[k], smp_data[k],
            smp_ch[k], smp_last[k], overrun[k], timeout_err[k]};
  endfunction

  // Event logs, sampled on the falling edge.
  ev_t st0[$], sm0[$], st1[$], sm1[$];
  int  ov0[$], to0[$], to1[$];
  int  stab_err = 0;
  logic        pv [2] = '{1'b0, 1'b0};
  logic        pr [2] = '{1'b0, 1'b0};
  logic [11:0] pd [2] = '{12'h0, 12'h0};
  logic [2:0]  pc [2] = '{3'd0, 3'd0};
  logic        pl [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    if (reset_n) begin
      if (spi_start[0]) st0.push_back(mk(cyc, int'(spi_addr[0]), 0, 0));
      if (smp_valid[0] && smp_ready[0])
        sm0.push_back(mk(cyc, int'(smp_ch[0]), int'(smp_data[0]), int'(smp_last[0])));
      if (overrun[0])     ov0.push_back(cyc);
      if (timeout_err[0]) to0.push_back(cyc);
      if (spi_start[1]) st1.push_back(mk(cyc, int'(spi_addr[1]), 0, 0));
      if (smp_valid[1] && smp_ready[1])
        sm1.push_back(mk(cyc, int'(smp_ch[1]), int'(smp_data[1]), int'(smp_last[1])));
      if (timeout_err[1]) to1.push_back(cyc);
      // cyc == 0 is the cycle right after a reset edge, where valid may drop.
      for (int k = 0; k < 2; k++) begin
        if (cyc != 0 && pv[k] && !pr[k] &&
            (!smp_valid[k] || smp_data[k] != pd[k] || smp_ch[k] != pc[k] || smp_last[k] != pl[k]))
          stab_err++;
      end
    end
    for (int k = 0; k < 2; k++) begin
      pv[k] = smp_valid[k]; pr[k] = smp_ready[k];
      pd[k] = smp_data[k];  pc[k] = smp_ch[k]; pl[k] = smp_last[k];
    end
  end

  task automatic clear_logs();
    st0.delete(); sm0.delete(); st1.delete(); sm1.delete();
    ov0.delete(); to0.delete(); to1.delete();
    stab_err = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_logs();
  endtask

  // Advance to #1 after the edge that starts cycle c.
  task automatic wait_cyc(input int c);
    for (int g = 0; g < 20000 && cyc < c; g++) begin
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (cyc != c) begin
      n_err++;
      $display("FAIL wait_cyc: reached cyc %0d, required %0d", cyc, c);
    end
  endtask

  task automatic test_reset();
    ch_en[0] = 8'hA5; ch_en[1] = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (outs(k) !== 23'd0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d: got %h need 0", k, outs(k));
      end
    end
    reset_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_frame();
    ev_t es[$], em[$];
    int  eo[$];
    ch_en[0] = 8'hA5; lat[0] = 34; smp_ready[0] = 1'b1;
    do_reset();
    wait_cyc(260);
    es = '{mk(65,0,0,0), mk(102,2,0,0), mk(139,5,0,0), mk(176,7,0,0), mk(257,0,0,0)};
    em = '{mk(100,0,171,0), mk(137,2,1195,0), mk(174,5,2731,0), mk(211,7,3755,1)};
    eo = '{128, 192};
    n_vec++;
    if (st0.size() != es.size()) begin n_err++; $display("FAIL frame_starts: got %0d need %0d", st0.size(), es.size()); end
    for (int i = 0; i < es.size() && i < st0.size(); i++) begin
      n_vec++;
      if (st0[i] !== es[i]) begin n_err++; $display("FAIL frame_start[%0d]: got cyc %0d ch %0d need cyc %0d ch %0d", i, st0[i].c, st0[i].a, es[i].c, es[i].a); end
    end
    n_vec++;
    if (sm0.size() != em.size()) begin n_err++; $display("FAIL frame_samples: got %0d need %0d", sm0.size(), em.size()); end
    for (int i = 0; i < em.size() && i < sm0.size(); i++) begin
      n_vec++;
      if (sm0[i] !== em[i]) begin n_err++; $display("FAIL frame_smp[%0d]: got cyc %0d ch %0d data %0h last %0d need cyc %0d ch %0d data %0h last %0d", i, sm0[i].c, sm0[i].a, sm0[i].d, sm0[i].l, em[i].c, em[i].a, em[i].d, em[i].l); end
    end
    n_vec++;
    if (ov0 != eo) begin n_err++; $display("FAIL frame_overrun: got %p need %p", ov0, eo); end
    n_vec++;
    if (to0.size() != 0) begin n_err++; $display("FAIL frame_timeout: got %0d need 0", to0.size()); end
    $display("test_frame done: %0d starts, %0d samples", st0.size(), sm0.size());
  endtask

  task automatic test_backpressure();
    ev_t es[$], em[$];
    ch_en[0] = 8'hA5; lat[0] = 34; smp_ready[0] = 1'b1;
    do_reset();
    wait_cyc(137);
    smp_ready[0] = 1'b0;
    wait_cyc(150);
    n_vec++;
    if ({smp_valid[0], smp_ch[0], smp_data[0]} !== {1'b1, 3'd2, 12'd1195}) begin
      n_err++;
      $display("FAIL bp_hold: got valid %b ch %0d data %0h need 1 2 4ab", smp_valid[0], smp_ch[0], smp_data[0]);
    end
    wait_cyc(157);
    smp_ready[0] = 1'b1;
    wait_cyc(258);
    es = '{mk(65,0,0,0), mk(102,2,0,0), mk(159,5,0,0), mk(196,7,0,0), mk(257,0,0,0)};
    em = '{mk(100,0,171,0), mk(157,2,1195,0), mk(194,5,2731,0), mk(231,7,3755,1)};
    n_vec++;
    if (st0.size() != es.size()) begin n_err++; $display("FAIL bp_starts: got %0d need %0d", st0.size(), es.size()); end
    for (int i = 0; i < es.size() && i < st0.size(); i++) begin
      n_vec++;
      if (st0[i] !== es[i]) begin n_err++; $display("FAIL bp_start[%0d]: got cyc %0d ch %0d need cyc %0d ch %0d", i, st0[i].c, st0[i].a, es[i].c, es[i].a); end
    end
    n_vec++;
    if (sm0.size() != em.size()) begin n_err++; $display("FAIL bp_samples: got %0d need %0d", sm0.size(), em.size()); end
    for (int i = 0; i < em.size() && i < sm0.size(); i++) begin
      n_vec++;
      if (sm0[i] !== em[i]) begin n_err++; $display("FAIL bp_smp[%0d]: got cyc %0d ch %0d data %0h last %0d need cyc %0d ch %0d data %0h last %0d", i, sm0[i].c, sm0[i].a, sm0[i].d, sm0[i].l, em[i].c, em[i].a, em[i].d, em[i].l); end
    end
    n_vec++;
    if (stab_err != 0) begin n_err++; $display("FAIL bp_stability: got %0d payload changes need 0", stab_err); end
    $display("test_backpressure done: %0d samples", sm0.size());
  endtask

  task automatic test_overrun();
    ev_t es[$];
    int  eo[$];
    ch_en[0] = 8'hFF; lat[0] = 50; smp_ready[0] = 1'b1;
    do_reset();
    wait_cyc(514);
    for (int i = 0; i < 8; i++) es.push_back(mk(65 + 53 * i, i, 0, 0));
    es.push_back(mk(513, 0, 0, 0));
    eo = '{128, 192, 256, 320, 384, 448};
    n_vec++;
    if (st0.size() != es.size()) begin n_err++; $display("FAIL ovr_starts: got %0d need %0d", st0.size(), es.size()); end
    for (int i = 0; i < es.size() && i < st0.size(); i++) begin
      n_vec++;
      if (st0[i] !== es[i]) begin n_err++; $display("FAIL ovr_start[%0d]: got cyc %0d ch %0d need cyc %0d ch %0d", i, st0[i].c, st0[i].a, es[i].c, es[i].a); end
    end
    n_vec++;
    if (sm0.size() != 8) begin n_err++; $display("FAIL ovr_samples: got %0d need 8", sm0.size()); end
    for (int i = 0; i < 8 && i < sm0.size(); i++) begin
      n_vec++;
      if (sm0[i] !== mk(116 + 53 * i, i, i * 512 + 171, (i == 7) ? 1 : 0)) begin
        n_err++;
        $display("FAIL ovr_smp[%0d]: got cyc %0d ch %0d data %0h last %0d need cyc %0d ch %0d", i, sm0[i].c, sm0[i].a, sm0[i].d, sm0[i].l, 116 + 53 * i, i);
      end
    end
    n_vec++;
    if (ov0 != eo) begin n_err++; $display("FAIL ovr_pulses: got %p need %p", ov0, eo); end
    $display("test_overrun done: %0d overrun pulses", ov0.size());
  endtask

  task automatic test_timeout();
    ev_t es[$];
    int  eto[$];
    ch_en[0] = 8'h00; ch_en[1] = 8'b0000_1100;
    lat[1] = 5; never_ch[1] = 2; smp_ready[1] = 1'b1;
    do_reset();
    wait_cyc(100);
    es  = '{mk(65,2,0,0), mk(83,3,0,0)};
    eto = '{82};
    n_vec++;
    if (to1 != eto) begin n_err++; $display("FAIL to_pulse: got %p need %p", to1, eto); end
    n_vec++;
    if (st1.size() != es.size()) begin n_err++; $display("FAIL to_starts: got %0d need %0d", st1.size(), es.size()); end
    for (int i = 0; i < es.size() && i < st1.size(); i++) begin
      n_vec++;
      if (st1[i] !== es[i]) begin n_err++; $display("FAIL to_start[%0d]: got cyc %0d ch %0d need cyc %0d ch %0d", i, st1[i].c, st1[i].a, es[i].c, es[i].a); end
    end
    n_vec++;
    if (sm1.size() != 1) begin n_err++; $display("FAIL to_samples: got %0d need 1", sm1.size()); end
    else begin
      n_vec++;
      if (sm1[0] !== mk(89, 3, 1707, 1)) begin n_err++; $display("FAIL to_smp: got cyc %0d ch %0d data %0h last %0d need cyc 89 ch 3 data 6ab last 1", sm1[0].c, sm1[0].a, sm1[0].d, sm1[0].l); end
    end
    ch_en[1] = 8'h00;
    $display("test_timeout done: %0d timeouts", to1.size());
  endtask

  task automatic test_disabled_mask();
    ev_t es[$], em[$];
    int  eo[$];
    ch_en[0] = 8'h00; lat[0] = 34; smp_ready[0] = 1'b1;
    do_reset();
    wait_cyc(330);
    n_vec++;
    if (st0.size() + ov0.size() + sm0.size() != 0) begin
      n_err++;
      $display("FAIL disabled_quiet: got %0d starts %0d overruns %0d samples need 0", st0.size(), ov0.size(), sm0.size());
    end
    ch_en[0] = 8'h03;
    wait_cyc(400);
    ch_en[0] = 8'h80;
    wait_cyc(550);
    es = '{mk(385,0,0,0), mk(422,1,0,0), mk(513,7,0,0)};
    em = '{mk(420,0,171,0), mk(457,1,683,1), mk(548,7,3755,1)};
    eo = '{448};
    n_vec++;
    if (st0.size() != es.size()) begin n_err++; $display("FAIL mask_starts: got %0d need %0d", st0.size(), es.size()); end
    for (int i = 0; i < es.size() && i < st0.size(); i++) begin
      n_vec++;
      if (st0[i] !== es[i]) begin n_err++; $display("FAIL mask_start[%0d]: got cyc %0d ch %0d need cyc %0d ch %0d", i, st0[i].c, st0[i].a, es[i].c, es[i].a); end
    end
    n_vec++;
    if (sm0.size() != em.size()) begin n_err++; $display("FAIL mask_samples: got %0d need %0d", sm0.size(), em.size()); end
    for (int i = 0; i < em.size() && i < sm0.size(); i++) begin
      n_vec++;
      if (sm0[i] !== em[i]) begin n_err++; $display("FAIL mask_smp[%0d]: got cyc %0d ch %0d data %0h last %0d need cyc %0d ch %0d data %0h last %0d", i, sm0[i].c, sm0[i].a, sm0[i].d, sm0[i].l, em[i].c, em[i].a, em[i].d, em[i].l); end
    end
    n_vec++;
    if (ov0 != eo) begin n_err++; $display("FAIL mask_overrun: got %p need %p", ov0, eo); end
    $display("test_disabled_mask done: %0d starts", st0.size());
  endtask

  task automatic test_reset_midframe();
    ch_en[0] = 8'hA5; lat[0] = 34; smp_ready[0] = 1'b1;
    do_reset();
    // Reset while ch0 is in WAIT; its done arrives later, at new cyc 18.
    wait_cyc(80);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (outs(0) !== 23'd0) begin n_err++; $display("FAIL rst_wait_outputs: got %h need 0", outs(0)); end
    reset_n = 1'b1;
    clear_logs();
    wait_cyc(90);
    smp_ready[0] = 1'b0;
    wait_cyc(105);
    n_vec++;
    if (st0.size() != 1 || sm0.size() != 0 || (st0.size() == 1 && st0[0] !== mk(65,0,0,0))) begin
      n_err++;
      $display("FAIL rst_late_done: got %0d starts %0d samples need 1 start at 65 and 0 samples", st0.size(), sm0.size());
    end
    n_vec++;
    if ({smp_valid[0], smp_ch[0], smp_data[0]} !== {1'b1, 3'd0, 12'd171}) begin
      n_err++;
      $display("FAIL rst_out_hold: got valid %b ch %0d data %0h need 1 0 0ab", smp_valid[0], smp_ch[0], smp_data[0]);
    end
    // Reset while the sample sits in OUT.
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (outs(0) !== 23'd0) begin n_err++; $display("FAIL rst_out_outputs: got %h need 0", outs(0)); end
    reset_n = 1'b1;
    smp_ready[0] = 1'b1;
    clear_logs();
    wait_cyc(101);
    n_vec++;
    if (st0.size() != 1 || (st0.size() == 1 && st0[0] !== mk(65,0,0,0))) begin
      n_err++; $display("FAIL rst_restart_start: got %0d starts need 1 at cyc 65 ch 0", st0.size());
    end
    n_vec++;
    if (sm0.size() != 1 || (sm0.size() == 1 && sm0[0] !== mk(100,0,171,0))) begin
      n_err++; $display("FAIL rst_restart_smp: got %0d samples need 1 at cyc 100 ch 0", sm0.size());
    end
    $display("test_reset_midframe done");
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_overrun();
    test_timeout();
    test_disabled_mask();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_adc_scheduler

// File: doc/adc_scheduler.md
# adc_scheduler

Frame scheduler for the 8-channel, 12-bit SPI ADC front end of the pedal. Once per sample period it walks the enabled channels in ascending order. For each channel it starts one conversion on the SPI engine and waits for the result. It then hands the tagged sample downstream over a valid/ready handshake. It sits between the SPI engine (start/done handshake) and the effects datapath, and replaces free-running capture and ad-hoc sampling counters.

## Interface
Parameters:
- DIV, 1042 — clk cycles per sample period (≈48 kHz at 50 MHz); legal ≥ 64
- TIMEOUT, 255 — max clk cycles waited for spi_done before abandoning a conversion

Ports:
- clk  in  1  system clock; one clock domain
- reset_n  in  1  synchronous, active-low reset
- ch_enable  in  8  channel mask; bit i enables ADC input i
- spi_start  out  1  one-cycle pulse: begin conversion of spi_addr
- spi_addr  out  3  channel address; stable from spi_start until done or timeout
- spi_done  in  1  one-cycle pulse from SPI engine: spi_data valid this cycle
- spi_data  in  12  conversion result
- smp_valid  out  1  sample available
- smp_ready  in  1  downstream accepts
- smp_data  out  12  sample value
- smp_ch  out  3  channel of smp_data
- smp_last  out  1  sample is last enabled channel of current frame
- overrun  out  1  one-cycle pulse: sample tick arrived while frame still in progress
- timeout_err  out  1  one-cycle pulse: conversion abandoned

## Operation
- Tick counter runs 0..DIV-1 and wraps. It is free-running, independent of FSM state. tick = (count == DIV-1).
- Frame state: rem_mask (8b), ch (3b), wait counter (8b).
- IDLE: on tick with ch_enable ≠ 0, latch rem_mask ← ch_enable and go to SCAN. With ch_enable = 0, stay in IDLE silently.
- SCAN (1 cycle): rem_mask == 0 → IDLE. Otherwise ch ← index of lowest set bit, clear that bit in rem_mask, go to START.
- START (1 cycle): spi_start = 1, spi_addr = ch, clear wait counter, go to WAIT.
- WAIT: on spi_done, register smp_data ← spi_data, smp_ch ← ch, smp_last ← (rem_mask == 0), go to OUT. If the wait counter reaches TIMEOUT first, pulse timeout_err, emit no sample, go to SCAN.
- OUT: smp_valid = 1. smp_data, smp_ch and smp_last are held until smp_valid && smp_ready, then go to SCAN.
- Tick in any state other than IDLE: pulse overrun and drop that frame. It is not queued, and the current frame continues.
- A tick coinciding with the OUT→SCAN handshake counts as overrun.
- ch_enable is sampled only at frame start. Mid-frame changes take effect next frame.
- spi_done outside WAIT is ignored.
- Reset (any state, mid-conversion included): state IDLE, counter 0, rem_mask 0. All outputs 0: spi_start, spi_addr, smp_valid, smp_data, smp_ch, smp_last, overrun, timeout_err.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from smp_ready or spi_done to any output.
- Tick in cycle T (IDLE) → SCAN at T+1 → spi_start high at T+2.
- spi_done in cycle D → smp_valid high at D+1.
- Handshake in cycle H → SCAN at H+1 → next spi_start at H+2.
- Timeout: spi_start in cycle S with no done → timeout_err in cycle S+1+TIMEOUT.
- The valid/ready rule is AXI-style: once valid is asserted it holds until accepted, and payload is stable while valid && !ready.

## Structure
- Package adc_pkg: ADC_DATA_W = 12, ADC_ADDR_W = 3, ADC_NUM_CH = 8, and the enum sched_state_t {IDLE, SCAN, START, WAIT, OUT}. The SPI engine and downstream consumers share this package.
- Sub-module sample_tick_gen (parameter DIV; ports clk, reset_n, tick) holds the free-running divider.
- Lowest-set-bit encoder is a function in adc_pkg.

## Test plan
- DIV = 64, ch_enable = 8'b1010_0101, SPI model returns done 34 cycles after start with data = {ch, 9'h0AB}, smp_ready = 1 → four samples per frame, ch 0, 2, 5, 7; smp_last only on ch 7; first spi_start 2 cycles after tick.
- Same setup, smp_ready low for 20 cycles on ch 2 → smp_valid held, payload stable, ch 5 start delayed to handshake+2; no data loss.
- Done latency 50 cycles, 8 channels enabled, DIV = 64 → overrun pulses once per dropped tick; frames complete in order, with no partial frame restarted.
- SPI model never returns done on ch 2 with TIMEOUT = 16 → timeout_err exactly 17 cycles after that start; no sample for ch 2; ch 3 proceeds.
- ch_enable = 0 across 5 ticks → no spi_start, no overrun. Mask changed mid-frame → applied next frame only.
- reset_n low during WAIT and again during OUT → all outputs 0 next cycle; late spi_done ignored; next frame starts cleanly at tick.
